// File: rtl/udp_dram_pkg.sv
// Shared types for the UDP-receive-to-DRAM writer:
// bridge word layouts, strobe constant and FSM encoding.
package udp_dram_pkg;

  localparam int DATA_W = 36;
  localparam int CTRL_W = 40;

  localparam int D_DATA_LSB = 0;
  localparam int D_STRB_LSB = 32;
  localparam int C_ADDR_LSB = 0;
  localparam int C_LEN_LSB  = 32;

  localparam logic [3:0] STRB_FULL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_HDR,
    ST_DATA,
    ST_FLUSH
  } state_t;

  function automatic logic [DATA_W-1:0] pack_data(
    input logic [31:0] d
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[D_DATA_LSB +: 32] = d;
    w[D_STRB_LSB +: 4]  = STRB_FULL;
    return w;
  endfunction

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic [7:0]  len,
    input logic [31:0] addr
  );
    logic [CTRL_W-1:0] w;
    w = '0;
    w[C_ADDR_LSB +: 32] = addr;
    w[C_LEN_LSB +: 8]   = len;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts after last grant.
// req in, en commits the grant; grant_oh/grant_idx/grant_vld out.
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant_oh,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_vld
);

  logic [CH_W-1:0] last;
  logic [CH_W-1:0] idx;
  int              idx_i;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx_i     = 0;
    idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_i = (int'(last) + i) % NUM_CH;
      idx   = idx_i[CH_W-1:0];
      if (!grant_vld && req[idx]) begin
        grant_vld     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

  // Pointer starts at the top channel so channel 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last <= CH_W'(NUM_CH - 1);
    else if (en && grant_vld)
      last <= grant_idx;
  end

endmodule

// File: rtl/udp_rx_dram_writer.sv
// Multi-channel UDP receive to AXI write-FIFO engine; splits packets
// into bursts (MAX_BURST, 4 KB, window wrap). Ports: rx_req/ack/enable/
// data per channel, wr_afull, data_in/we, ctrl_in/we, busy, active_ch,
// stat_pkt. Macro UDP_RX_DRAM_WRITER_STATS_EN builds packet counters.
module udp_rx_dram_writer
  import udp_dram_pkg::*;
#(
  parameter  int          NUM_CH    = 2,
  parameter  int          MAX_BURST = 64,
  parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter  int          WIN_LOG2  = 24,
  localparam int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    rx_req,
  output logic [NUM_CH-1:0]    rx_ack,
  input  logic [NUM_CH-1:0]    rx_enable,
  input  logic [32*NUM_CH-1:0] rx_data,
  input  logic                 wr_afull,
  output logic [DATA_W-1:0]    data_in,
  output logic                 data_we,
  output logic [CTRL_W-1:0]    ctrl_in,
  output logic                 ctrl_we,
  output logic                 busy,
  output logic [CH_W-1:0]      active_ch,
  output logic [16*NUM_CH-1:0] stat_pkt
);

  localparam logic [31:0] WIN_MASK =
    (32'd1 << WIN_LOG2) - 32'd1;

  state_t            state;
  logic [NUM_CH-1:0] g_oh;
  logic [CH_W-1:0]   g_idx;
  logic              g_vld;
  logic              arb_go;

  logic [31:0]       win_base;
  logic [31:0]       woff;
  logic [31:0]       bstart;
  logic [8:0]        beats;
  logic              close_q;
  logic [CTRL_W-1:0] close_word;

  logic              cur_en;
  logic [31:0]       cur_data;
  logic [31:0]       hdr_base;
  logic [31:0]       hdr_woff;
  logic [31:0]       nxt_woff;
  logic [31:0]       nxt_addr;
  logic [8:0]        beats_inc;
  logic [8:0]        beats_dec;
  logic              close_now;

  assign arb_go = (state == ST_IDLE) && !wr_afull;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (rx_req),
    .en        (arb_go),
    .grant_oh  (g_oh),
    .grant_idx (g_idx),
    .grant_vld (g_vld)
  );

  assign cur_en    = rx_enable[active_ch];
  assign cur_data  = rx_data[32*int'(active_ch) +: 32];
  assign hdr_base  = BASE_ADDR
                   + (32'(active_ch) << WIN_LOG2);
  assign hdr_woff  = {cur_data[29:0], 2'b00} & WIN_MASK;
  assign nxt_woff  = (woff + 32'd4) & WIN_MASK;
  assign nxt_addr  = win_base + nxt_woff;
  assign beats_inc = beats + 9'd1;
  assign beats_dec = beats - 9'd1;

  // Close on full burst, 4 KB boundary ahead, or window wrap.
  assign close_now = (beats_inc == 9'(MAX_BURST))
                  || (nxt_addr[11:0] == 12'h000)
                  || (nxt_woff == 32'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rx_ack     <= '0;
      data_in    <= '0;
      data_we    <= 1'b0;
      ctrl_in    <= '0;
      ctrl_we    <= 1'b0;
      busy       <= 1'b0;
      active_ch  <= '0;
      win_base   <= '0;
      woff       <= '0;
      bstart     <= '0;
      beats      <= '0;
      close_q    <= 1'b0;
      close_word <= '0;
    end else begin
      rx_ack  <= '0;
      data_we <= 1'b0;
      close_q <= 1'b0;
      // A closed burst's ctrl word trails its last data beat.
      ctrl_we <= close_q;
      if (close_q)
        ctrl_in <= close_word;
      unique case (state)
        ST_IDLE: begin
          if (arb_go && g_vld) begin
            active_ch <= g_idx;
            rx_ack    <= g_oh;
            busy      <= 1'b1;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_HDR;
        end
        ST_HDR: begin
          if (cur_en) begin
            win_base <= hdr_base;
            woff     <= hdr_woff;
            bstart   <= hdr_base + hdr_woff;
            beats    <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (cur_en) begin
            data_in <= pack_data(cur_data);
            data_we <= 1'b1;
            woff    <= nxt_woff;
            if (close_now) begin
              close_q    <= 1'b1;
              close_word <= pack_ctrl(beats[7:0], bstart);
              beats      <= '0;
              bstart     <= nxt_addr;
            end else begin
              beats <= beats_inc;
            end
          end else begin
            if (beats != 9'd0) begin
              ctrl_we <= 1'b1;
              ctrl_in <= pack_ctrl(beats_dec[7:0], bstart);
            end
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UDP_RX_DRAM_WRITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stat_pkt <= '0;
    else if (state == ST_FLUSH)
      stat_pkt[16*int'(active_ch) +: 16] <=
        stat_pkt[16*int'(active_ch) +: 16] + 16'd1;
  end
`else
  assign stat_pkt = '0;
`endif

endmodule
